pipeline_checker_mc: RTL
========================

Name: pipeline_checker_mc

Overview:
- Multi-channel, parametrised traffic generator and scoreboard for valid/ready pipelines (FIFOs, register slices, crossbar paths).
- Each channel drives a pseudo-random data stream into a DUT input port and checks the DUT output port against an identical expected stream.
- Adds programmable valid/ready throttling, a finite beat budget with done reporting, per-channel sticky errors, a saturating error counter and first-mismatch capture.

Parameters:
- NB_CH, 2, number of independent channels (1..16)
- DATA_BUS_W, 64, data width per channel in bits (any value ≥1)
- KEY, 32'h4A5B3C86, base seed; channel c seed = KEY ^ (c * 32'h9E3779B9), forced to 32'h1 if result is 0
- NB_BEATS, 256, beats per channel before done; 0 = run forever
- TIMEOUT, 1024, stall cycles before timeout flag (optional feature only)

Ports:
- aclk  in  1  clock
- aresetn  in  1  asynchronous active-low reset
- srst  in  1  synchronous reset, same effect as aresetn
- en  in  1  enables generation; when 0, no new valid is raised and throttle LFSRs freeze
- i_throttle  in  8  valid throttle threshold, shared by all channels
- o_throttle  in  8  ready throttle threshold, shared by all channels
- i_valid  out  NB_CH  per-channel input valid to DUT
- i_ready  in  NB_CH  per-channel input ready from DUT
- i_data  out  NB_CH*DATA_BUS_W  per-channel input data; channel c at [c*W +: W]
- o_valid  in  NB_CH  per-channel output valid from DUT
- o_ready  out  NB_CH  per-channel output ready to DUT
- o_data  in  NB_CH*DATA_BUS_W  per-channel output data from DUT
- error  out  NB_CH  per-channel sticky mismatch flag
- err_cnt  out  16  total mismatching beats, saturating at 16'hFFFF
- first_err_ch  out  4  channel of first mismatch
- first_err_beat  out  16  output beat index of first mismatch
- done  out  1  all channels completed NB_BEATS output beats
- timeout  out  1  sticky watchdog flag (tied 0 when feature is off)

Behaviour:
- Reset (aresetn low or srst high): i_valid=0, o_ready=0, error=0, err_cnt=0, first_err_*=0, done=0, timeout=0.
  - Data LFSRs reload their seeds; beat counters clear; throttle LFSRs reload seed ^ 32'hA5A5A5A5.
  - aresetn is asynchronous; srst takes effect at the next clock edge.
  - Reset mid-burst drops all in-flight state; no error is flagged afterwards.
- LFSR: 32-bit Galois, polynomial x^32+x^22+x^2+x+1. Advances only on a handshake of its own side: input generator on i_valid&i_ready, expected generator on o_valid&o_ready.
- Data width: word k (k = 0..ceil(W/32)-1) = lfsr ^ (k * 32'h9E3779B9); words concatenated LSB-first and truncated to DATA_BUS_W.
- Valid rule (per channel): when i_valid=0 and en=1 and the input beat count < NB_BEATS, raise i_valid if throttle_byte ≥ i_throttle.
  - i_throttle=0 gives continuous valid.
  - Once raised, i_valid and i_data hold until i_ready; no retraction.
- Ready rule: o_ready is registered and recomputed every cycle as (o_tlfsr[7:0] ≥ o_throttle) & en. It may toggle freely.
- Check: on o_valid&o_ready, compare o_data with expected data.
  - On mismatch: set error[c]; add the number of mismatching channels in that cycle to err_cnt (saturating).
  - On the first mismatch since reset: capture first_err_ch and first_err_beat. If several channels mismatch in that same cycle, capture the lowest channel index.
- Beat counters: input and output, 16-bit per channel; they stop incrementing at NB_BEATS.
  - Output beats beyond NB_BEATS are still checked against the LFSR stream.
- done: registered, asserted the cycle after the last channel's output count reaches NB_BEATS. Sticky until reset. Never asserts when NB_BEATS=0.
- Channels are fully independent; simultaneous handshakes on all channels are legal.
- First output beat latency from en rising: 1 cycle (registered valid).

Optional Feature:
- Macro: PIPELINE_CHECKER_TIMEOUT_EN.
- Defined: per-channel stall counter clears on any o handshake or when output count = input count. Otherwise it increments while en=1. When it reaches TIMEOUT, timeout sets (sticky).
- Undefined: no counters are built and timeout is tied to 0.

Decomposition:
- Package pipeline_checker_pkg: LFSR polynomial constant, golden-ratio constant 32'h9E3779B9, throttle seed mask 32'hA5A5A5A5, and a function expanding a 32-bit LFSR value to W bits.
- Sub-module checker_lane: one channel holding both generators, throttles, counters and compare. It outputs a mismatch pulse and its beat index.
- Top level: generate loop over lanes, error aggregation and saturation, first-error capture, done, timeout OR-reduction.

Test Plan:
- Loopback wire (o=i, o_valid=i_valid, i_ready=o_ready), throttles 0, NB_BEATS=256 -> done at cycle 257 after en, err_cnt=0, error=0.
- Loopback with i_throttle=8'hC0, o_throttle=8'h80 -> no valid retraction while ready=0, done asserts, err_cnt=0.
- Invert bit 0 of ch1 o_data on output beat 10 only -> error=2'b10, err_cnt=1, first_err_ch=1, first_err_beat=10.
- Corrupt both channels on the same beat 5 -> err_cnt=2, first_err_ch=0.
- Force o_valid stuck 0 with PIPELINE_CHECKER_TIMEOUT_EN, TIMEOUT=1024 -> timeout=1 after 1024 stalled cycles; without macro, timeout stays 0.
- Pulse aresetn mid-burst at beat 100, then restart -> all outputs return to reset values, stream restarts from seed, done later with err_cnt=0.

Source files
------------

// File: rtl/pipeline_checker_pkg.sv
// Shared constants and helpers for the pipeline_checker_mc traffic generator / scoreboard.
package pipeline_checker_pkg;

   // Galois taps for x^32 + x^22 + x^2 + x + 1 in right-shift form.
   localparam logic [31:0] LFSR_POLY  = 32'h8020_0003;
   localparam logic [31:0] GOLDEN     = 32'h9E37_79B9;
   localparam logic [31:0] THR_MASK   = 32'hA5A5_A5A5;
   localparam int          MAX_DATA_W = 1024;

   function automatic logic [31:0] lfsr_step(input logic [31:0] s);
      return {1'b0, s[31:1]} ^ (s[0] ? LFSR_POLY : 32'h0);
   endfunction

   // Word k of a beat is the LFSR value XORed with k times the golden-ratio constant.
   function automatic logic [MAX_DATA_W-1:0] expand_data(input logic [31:0] s);
      logic [MAX_DATA_W-1:0] v;
      v = '0;
      for (int k = 0; k < MAX_DATA_W / 32; k++) begin
         v[k*32 +: 32] = s ^ (32'(k) * GOLDEN);
      end
      return v;
   endfunction

   function automatic logic [31:0] lane_seed(input logic [31:0] key, input int c);
      logic [31:0] s;
      s = key ^ (32'(c) * GOLDEN);
      return (s == 32'h0) ? 32'h1 : s;
   endfunction

endpackage

// File: rtl/pipeline_checker_mc_lane.sv
// checker_lane: one channel's input generator, throttles, beat counters and output compare.
// The per-lane stall counter exists only when PIPELINE_CHECKER_TIMEOUT_EN is defined.
module checker_lane
   import pipeline_checker_pkg::*;
#(
   parameter int          DATA_BUS_W = 64,
   parameter int          NB_BEATS   = 256,
`ifdef PIPELINE_CHECKER_TIMEOUT_EN
   parameter int          TIMEOUT    = 1024,
`endif
   parameter logic [31:0] SEED       = 32'h1
) (
   input  logic                  aclk,
   input  logic                  aresetn,
   input  logic                  i_srst,
   input  logic                  i_en,
   input  logic [7:0]            i_vthr,
   input  logic [7:0]            i_rthr,
   output logic                  o_in_valid,
   input  logic                  i_in_ready,
   output logic [DATA_BUS_W-1:0] o_in_data,
   input  logic                  i_out_valid,
   output logic                  o_out_ready,
   input  logic [DATA_BUS_W-1:0] i_out_data,
   output logic                  o_mismatch,
   output logic [15:0]           o_beat,
   output logic                  o_done
`ifdef PIPELINE_CHECKER_TIMEOUT_EN
  ,output logic                  o_stall
`endif
);

   localparam logic [15:0] BEATS   = 16'(NB_BEATS);
   localparam bit          LIMITED = (NB_BEATS != 0);

   logic [31:0]           r_gen_lfsr;
   logic [31:0]           r_exp_lfsr;
   logic [31:0]           r_thr_lfsr;
   logic [15:0]           r_in_cnt;
   logic [15:0]           r_out_cnt;
   logic                  r_valid;
   logic                  r_ready;
   logic                  w_in_hs;
   logic                  w_out_hs;
   logic                  w_in_full;
   logic                  w_out_full;
   logic                  w_in_room;
   logic [15:0]           w_in_cnt_nxt;
   logic [DATA_BUS_W-1:0] w_exp_data;

   assign w_in_hs      = r_valid & i_in_ready;
   assign w_out_hs     = i_out_valid & r_ready;
   assign w_in_full    = LIMITED && (r_in_cnt == BEATS);
   assign w_out_full   = LIMITED && (r_out_cnt == BEATS);
   assign w_in_cnt_nxt = (w_in_hs && !w_in_full) ? r_in_cnt + 16'd1 : r_in_cnt;
   assign w_in_room    = !LIMITED || (w_in_cnt_nxt < BEATS);

   assign o_in_data   = DATA_BUS_W'(expand_data(r_gen_lfsr));
   assign w_exp_data  = DATA_BUS_W'(expand_data(r_exp_lfsr));
   assign o_in_valid  = r_valid;
   assign o_out_ready = r_ready;
   assign o_mismatch  = w_out_hs && (i_out_data != w_exp_data);
   assign o_beat      = r_out_cnt;
   assign o_done      = w_out_full;

   // NOTE: srst is tested inside the clocked branch so it is synchronous; only aresetn is in the sensitivity list.
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_gen_lfsr <= SEED;
         r_exp_lfsr <= SEED;
         r_thr_lfsr <= SEED ^ THR_MASK;
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_valid    <= 1'b0;
         r_ready    <= 1'b0;
      end else if (i_srst) begin
         r_gen_lfsr <= SEED;
         r_exp_lfsr <= SEED;
         r_thr_lfsr <= SEED ^ THR_MASK;
         r_in_cnt   <= '0;
         r_out_cnt  <= '0;
         r_valid    <= 1'b0;
         r_ready    <= 1'b0;
      end else begin
         // NOTE: non-blocking assignments make every register here sample the pre-edge values.
         if (w_in_hs)  r_gen_lfsr <= lfsr_step(r_gen_lfsr);
         if (w_out_hs) r_exp_lfsr <= lfsr_step(r_exp_lfsr);
         if (i_en)     r_thr_lfsr <= lfsr_step(r_thr_lfsr);
         r_in_cnt <= w_in_cnt_nxt;
         if (w_out_hs && !w_out_full) r_out_cnt <= r_out_cnt + 16'd1;
         // A raised valid holds until accepted; a new one may follow in the same cycle.
         if (!r_valid || w_in_hs) r_valid <= i_en && w_in_room && (r_thr_lfsr[15:8] >= i_vthr);
         r_ready <= i_en && (r_thr_lfsr[7:0] >= i_rthr);
      end
   end

`ifdef PIPELINE_CHECKER_TIMEOUT_EN
   localparam logic [31:0] STALL_MAX = 32'(TIMEOUT);

   logic [31:0] r_stall_cnt;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_stall_cnt <= '0;
      end else if (i_srst || w_out_hs || (r_out_cnt == r_in_cnt)) begin
         r_stall_cnt <= '0;
      end else if (i_en && (r_stall_cnt != STALL_MAX)) begin
         r_stall_cnt <= r_stall_cnt + 32'd1;
      end
   end

   assign o_stall = (r_stall_cnt == STALL_MAX);
`endif

endmodule

// File: rtl/pipeline_checker_mc.sv
// Multi-channel valid/ready traffic generator and scoreboard: one checker_lane per channel plus aggregation.
// Defining PIPELINE_CHECKER_TIMEOUT_EN builds the stall watchdog; otherwise timeout is tied low.
module pipeline_checker_mc
   import pipeline_checker_pkg::*;
#(
   parameter int          NB_CH      = 2,
   parameter int          DATA_BUS_W = 64,
   parameter logic [31:0] KEY        = 32'h4A5B3C86,
   parameter int          NB_BEATS   = 256,
   parameter int          TIMEOUT    = 1024
) (
   input  logic                        aclk,
   input  logic                        aresetn,
   input  logic                        srst,
   input  logic                        en,
   input  logic [7:0]                  i_throttle,
   input  logic [7:0]                  o_throttle,
   output logic [NB_CH-1:0]            i_valid,
   input  logic [NB_CH-1:0]            i_ready,
   output logic [NB_CH*DATA_BUS_W-1:0] i_data,
   input  logic [NB_CH-1:0]            o_valid,
   output logic [NB_CH-1:0]            o_ready,
   input  logic [NB_CH*DATA_BUS_W-1:0] o_data,
   output logic [NB_CH-1:0]            error,
   output logic [15:0]                 err_cnt,
   output logic [3:0]                  first_err_ch,
   output logic [15:0]                 first_err_beat,
   output logic                        done,
   output logic                        timeout
);

   if (NB_CH < 1 || NB_CH > 16 || DATA_BUS_W < 1 || DATA_BUS_W > MAX_DATA_W || TIMEOUT < 1) begin : g_bad_cfg
      $error("pipeline_checker_mc: unsupported parameter set");
   end

   logic [NB_CH-1:0] w_mm;
   logic [NB_CH-1:0] w_lane_done;
   logic [15:0]      w_beat [NB_CH];
   logic [4:0]       w_nmm;
   logic [16:0]      w_sum;
   logic [3:0]       w_first_ch;
   logic [15:0]      w_first_beat;

   logic [NB_CH-1:0] r_error;
   logic [15:0]      r_err_cnt;
   logic             r_first_seen;
   logic [3:0]       r_first_ch;
   logic [15:0]      r_first_beat;
   logic             r_done;

`ifdef PIPELINE_CHECKER_TIMEOUT_EN
   logic [NB_CH-1:0] w_stall;
`endif

   for (genvar ch = 0; ch < NB_CH; ch++) begin : g_lane
      checker_lane #(
         .DATA_BUS_W (DATA_BUS_W),
         .NB_BEATS   (NB_BEATS),
`ifdef PIPELINE_CHECKER_TIMEOUT_EN
         .TIMEOUT    (TIMEOUT),
`endif
         .SEED       (lane_seed(KEY, ch))
      ) u_lane (
         .aclk        (aclk),
         .aresetn     (aresetn),
         .i_srst      (srst),
         .i_en        (en),
         .i_vthr      (i_throttle),
         .i_rthr      (o_throttle),
         .o_in_valid  (i_valid[ch]),
         .i_in_ready  (i_ready[ch]),
         .o_in_data   (i_data[ch*DATA_BUS_W +: DATA_BUS_W]),
         .i_out_valid (o_valid[ch]),
         .o_out_ready (o_ready[ch]),
         .i_out_data  (o_data[ch*DATA_BUS_W +: DATA_BUS_W]),
         .o_mismatch  (w_mm[ch]),
         .o_beat      (w_beat[ch]),
         .o_done      (w_lane_done[ch])
`ifdef PIPELINE_CHECKER_TIMEOUT_EN
        ,.o_stall     (w_stall[ch])
`endif
      );
   end

   // Count this cycle's mismatching lanes and pick the lowest-index one for first-error capture.
   always_comb begin
      // NOTE: every variable gets a default first so no latch is inferred.
      w_nmm        = '0;
      w_first_ch   = '0;
      w_first_beat = '0;
      for (int c = NB_CH - 1; c >= 0; c--) begin
         w_nmm = w_nmm + 5'(w_mm[c]);
         if (w_mm[c]) begin
            w_first_ch   = 4'(c);
            w_first_beat = w_beat[c];
         end
      end
   end

   assign w_sum = {1'b0, r_err_cnt} + 17'(w_nmm);

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_error      <= '0;
         r_err_cnt    <= '0;
         r_first_seen <= 1'b0;
         r_first_ch   <= '0;
         r_first_beat <= '0;
         r_done       <= 1'b0;
      end else if (srst) begin
         r_error      <= '0;
         r_err_cnt    <= '0;
         r_first_seen <= 1'b0;
         r_first_ch   <= '0;
         r_first_beat <= '0;
         r_done       <= 1'b0;
      end else begin
         r_error   <= r_error | w_mm;
         r_err_cnt <= w_sum[16] ? 16'hFFFF : w_sum[15:0];
         if (!r_first_seen && (|w_mm)) begin
            r_first_seen <= 1'b1;
            r_first_ch   <= w_first_ch;
            r_first_beat <= w_first_beat;
         end
         r_done <= r_done | (&w_lane_done);
      end
   end

   assign error          = r_error;
   assign err_cnt        = r_err_cnt;
   assign first_err_ch   = r_first_ch;
   assign first_err_beat = r_first_beat;
   assign done           = r_done;

`ifdef PIPELINE_CHECKER_TIMEOUT_EN
   logic r_timeout;

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         r_timeout <= 1'b0;
      end else if (srst) begin
         r_timeout <= 1'b0;
      end else begin
         r_timeout <= r_timeout | (|w_stall);
      end
   end

   assign timeout = r_timeout;
`else
   assign timeout = 1'b0;
`endif

endmodule
